cray_mem_loader: RTL and testbench

//  Memory responder for the CPU memory port of cray_top: a word-addressed 64-bit RAM.

---
 rtl/cray_mem_loader.sv | 149 ++++++++++++++
 tb/tb_cray_mem_loader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cray_mem_loader.sv
// cray_mem_loader: word-addressed 64-bit RAM serving the cray_top CPU memory port.
// It also accepts a host parcel stream that is packed four parcels per word and
// written from address 0. The CPU is held in reset until the image is complete.
module cray_mem_loader #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DEPTH_LOG2 = 9,
    // Four parcels fill one 64-bit word, so this is expected to be 16.
    parameter int unsigned PARCEL_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    input  logic [63:0]         i_mem_wr_data,
    input  logic                i_mem_wr_en,
    output logic [63:0]         o_mem_rd_data,
    input  logic                i_ld_valid,
    input  logic [PARCEL_W-1:0] i_ld_parcel,
    input  logic                i_ld_last,
    output logic                o_ld_ready,
    input  logic                i_ld_restart,
    output logic                o_cpu_rst,
    output logic                o_ld_ovf
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    localparam logic [0:0] StLoad = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [DEPTH_LOG2-1:0] AddrOne = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] AddrMax = '1;

    logic [63:0]           ram [Depth];

    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] ld_addr_q, ld_addr_d;
    logic [1:0]            pcnt_q, pcnt_d;
    logic [63:0]           pbuf_q, pbuf_d;
    logic                  ovf_q, ovf_d;

    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                  ld_accept;
    logic                  word_done;
    logic                  ld_we;
    logic                  cpu_we;
    logic [63:0]           ld_word;

    // Upper CPU address bits alias onto the RAM and are intentionally dropped.
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^i_mem_addr[ADDR_W-1:DEPTH_LOG2];

    assign mem_idx   = i_mem_addr[DEPTH_LOG2-1:0];
    assign ld_accept = i_ld_valid && (state_q == StLoad);
    assign word_done = ld_accept && ((pcnt_q == 2'd3) || i_ld_last);
    assign cpu_we    = i_mem_wr_en && (state_q == StRun);

    // Merge the incoming parcel into its slot; higher slots are still zero in pbuf.
    always_comb begin
        ld_word = pbuf_q;
        unique case (pcnt_q)
            2'd0: ld_word[PARCEL_W-1:0]            = i_ld_parcel;
            2'd1: ld_word[2*PARCEL_W-1:PARCEL_W]   = i_ld_parcel;
            2'd2: ld_word[3*PARCEL_W-1:2*PARCEL_W] = i_ld_parcel;
            2'd3: ld_word[4*PARCEL_W-1:3*PARCEL_W] = i_ld_parcel;
        endcase
    end

    // Loader FSM next state: parcel packing, address advance and overflow flag.
    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        pcnt_d    = pcnt_q;
        pbuf_d    = pbuf_q;
        ovf_d     = ovf_q;
        ld_we     = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (ld_accept) begin
                    if (word_done) begin
                        ld_we     = 1'b1;
                        ld_addr_d = ld_addr_q + AddrOne;
                        pcnt_d    = '0;
                        pbuf_d    = '0;
                        if (ld_addr_q == AddrMax) begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        pcnt_d = pcnt_q + 2'd1;
                        pbuf_d = ld_word;
                    end
                    if (i_ld_last) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (i_ld_restart) begin
                    state_d   = StLoad;
                    ld_addr_d = '0;
                    pcnt_d    = '0;
                    pbuf_d    = '0;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Loader state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLoad;
            ld_addr_q <= '0;
            pcnt_q    <= '0;
            pbuf_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            pcnt_q    <= pcnt_d;
            pbuf_q    <= pbuf_d;
            ovf_q     <= ovf_d;
        end
    end

    // RAM write port; CPU and loader writes are exclusive by state. Nothing commits in reset,
    // so a load interrupted by rst never writes its partial word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (cpu_we) begin
                ram[mem_idx] <= i_mem_wr_data;
            end else if (ld_we) begin
                ram[ld_addr_q] <= ld_word;
            end
        end
    end

    // Combinational read port; reads return zero while the CPU is writing.
    always_comb begin
        o_mem_rd_data = i_mem_wr_en ? 64'b0 : ram[mem_idx];
    end

    // Status outputs decoded from the FSM state.
    always_comb begin
        o_ld_ready = (state_q == StLoad);
        o_cpu_rst  = (state_q == StLoad);
        o_ld_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_cray_mem_loader.sv
// Self-checking bench for cray_mem_loader: a 512-word instance plus a 4-word instance
// for address wrap. Committed loader words are pushed to a scoreboard and read back.
module tb_cray_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [21:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic        mem_wr_en;
    logic [63:0] mem_rd_data;
    logic        ld_valid;
    logic [15:0] ld_parcel;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_restart;
    logic        cpu_rst;
    logic        ld_ovf;

    logic [21:0] s_mem_addr;
    logic [63:0] s_mem_wr_data;
    logic        s_mem_wr_en;
    logic [63:0] s_mem_rd_data;
    logic        s_ld_valid;
    logic [15:0] s_ld_parcel;
    logic        s_ld_last;
    logic        s_ld_ready;
    logic        s_ld_restart;
    logic        s_cpu_rst;
    logic        s_ld_ovf;

    cray_mem_loader u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_mem_addr    (mem_addr),
        .i_mem_wr_data (mem_wr_data),
        .i_mem_wr_en   (mem_wr_en),
        .o_mem_rd_data (mem_rd_data),
        .i_ld_valid    (ld_valid),
        .i_ld_parcel   (ld_parcel),
        .i_ld_last     (ld_last),
        .o_ld_ready    (ld_ready),
        .i_ld_restart  (ld_restart),
        .o_cpu_rst     (cpu_rst),
        .o_ld_ovf      (ld_ovf)
    );

    cray_mem_loader #(
        .DEPTH_LOG2 (2)
    ) u_small (
        .clk           (clk),
        .rst           (rst),
        .i_mem_addr    (s_mem_addr),
        .i_mem_wr_data (s_mem_wr_data),
        .i_mem_wr_en   (s_mem_wr_en),
        .o_mem_rd_data (s_mem_rd_data),
        .i_ld_valid    (s_ld_valid),
        .i_ld_parcel   (s_ld_parcel),
        .i_ld_last     (s_ld_last),
        .o_ld_ready    (s_ld_ready),
        .i_ld_restart  (s_ld_restart),
        .o_cpu_rst     (s_cpu_rst),
        .o_ld_ovf      (s_ld_ovf)
    );

    typedef struct {
        int          sel;
        int          addr;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Loader reference model, one slot per instance.
    int          m_addr [2];
    int          m_cnt  [2];
    logic [63:0] m_buf  [2];
    logic [63:0] img0   [512];

    task automatic sync;
        @(negedge clk);
    endtask

    task automatic model_reset(input int sel);
        m_addr[sel] = 0;
        m_cnt[sel]  = 0;
        m_buf[sel]  = 64'b0;
    endtask

    // Present one parcel for one edge (caller is at a negedge); the model commits
    // completed words to the scoreboard.
    task automatic put_parcel(input int sel, input logic [15:0] p, input logic last);
        int depth;
        exp_t e;
        depth = (sel == 0) ? 512 : 4;
        if (sel == 0) begin
            ld_valid = 1'b1; ld_parcel = p; ld_last = last;
        end else begin
            s_ld_valid = 1'b1; s_ld_parcel = p; s_ld_last = last;
        end
        m_buf[sel][16*m_cnt[sel] +: 16] = p;
        if (m_cnt[sel] == 3 || last) begin
            e.sel  = sel;
            e.addr = m_addr[sel];
            e.data = m_buf[sel];
            exp_q.push_back(e);
            if (sel == 0) img0[m_addr[sel]] = m_buf[sel];
            m_addr[sel] = (m_addr[sel] + 1) % depth;
            m_cnt[sel]  = 0;
            m_buf[sel]  = 64'b0;
        end else begin
            m_cnt[sel] = m_cnt[sel] + 1;
        end
        @(negedge clk);
        if (sel == 0) begin
            ld_valid = 1'b0; ld_last = 1'b0;
        end else begin
            s_ld_valid = 1'b0; s_ld_last = 1'b0;
        end
    endtask

    task automatic expect_word(input int sel, input int addr, input logic [63:0] data);
        exp_t e;
        e.sel  = sel;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Pop every expected word and compare it with a CPU-port read.
    task automatic drain(input string tag);
        exp_t e;
        logic [63:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            if (e.sel == 0) begin
                mem_wr_en = 1'b0; mem_addr = 22'(e.addr);
            end else begin
                s_mem_wr_en = 1'b0; s_mem_addr = 22'(e.addr);
            end
            #1;
            got = (e.sel == 0) ? mem_rd_data : s_mem_rd_data;
            n_cmp++;
            if (got !== e.data) begin
                n_bad++;
                $display("FAIL %s ram[0x%0h] dut%0d: got %h expected %h",
                         tag, e.addr, e.sel, got, e.data);
            end
        end
        sync;
    endtask

    task automatic restart(input int sel, input string tag);
        if (sel == 0) ld_restart = 1'b1; else s_ld_restart = 1'b1;
        sync;
        if (sel == 0) ld_restart = 1'b0; else s_ld_restart = 1'b0;
        model_reset(sel);
        n_cmp++;
        if (((sel == 0) ? cpu_rst : s_cpu_rst) !== 1'b1) begin
            n_bad++; $display("FAIL %s cpu_rst after restart: got 0 expected 1", tag);
        end
        n_cmp++;
        if (((sel == 0) ? ld_ready : s_ld_ready) !== 1'b1) begin
            n_bad++; $display("FAIL %s ld_ready after restart: got 0 expected 1", tag);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) sync;
        rst = 1'b0;
        model_reset(0);
        model_reset(1);
        sync;
        n_cmp++;
        if ({cpu_rst, ld_ready, ld_ovf} !== 3'b110) begin
            n_bad++; $display("FAIL reset main {cpu_rst,ready,ovf}: got %b expected 110",
                              {cpu_rst, ld_ready, ld_ovf});
        end
        n_cmp++;
        if ({s_cpu_rst, s_ld_ready, s_ld_ovf} !== 3'b110) begin
            n_bad++; $display("FAIL reset small {cpu_rst,ready,ovf}: got %b expected 110",
                              {s_cpu_rst, s_ld_ready, s_ld_ovf});
        end
        mem_wr_en = 1'b1;
        #1;
        n_cmp++;
        if (mem_rd_data !== 64'b0) begin
            n_bad++; $display("FAIL reset rd_data during wr_en: got %h expected 0", mem_rd_data);
        end
        mem_wr_en = 1'b0;
        sync;
    endtask

    task automatic test_image_load;
        logic [15:0] img [8];
        img = '{16'o072300, 16'o077230, 16'o155123, 16'o022106,
                16'o022106, 16'o034100, 16'o035100, 16'o036100};
        for (int i = 0; i < 7; i++) put_parcel(0, img[i], 1'b0);
        n_cmp++;
        if (cpu_rst !== 1'b1) begin
            n_bad++; $display("FAIL image cpu_rst before last: got %b expected 1", cpu_rst);
        end
        put_parcel(0, img[7], 1'b1);
        n_cmp++;
        if ({cpu_rst, ld_ready} !== 2'b00) begin
            n_bad++; $display("FAIL image {cpu_rst,ready} after last: got %b expected 00",
                              {cpu_rst, ld_ready});
        end
        drain("image");
    endtask

    task automatic test_short_image;
        logic [15:0] p;
        restart(0, "short");
        for (int i = 0; i < 5; i++) begin
            p = 16'($urandom_range(0, 65535));
            put_parcel(0, p, i == 4);
        end
        n_cmp++;
        if ({cpu_rst, ld_ovf} !== 2'b00) begin
            n_bad++; $display("FAIL short {cpu_rst,ovf}: got %b expected 00", {cpu_rst, ld_ovf});
        end
        drain("short");
    endtask

    task automatic test_cpu_write;
        mem_wr_en   = 1'b1;
        mem_addr    = 22'h100;
        mem_wr_data = 64'hDEAD_BEEF_0123_4567;
        #1;
        n_cmp++;
        if (mem_rd_data !== 64'b0) begin
            n_bad++; $display("FAIL cpuwr rd_data while wr_en: got %h expected 0", mem_rd_data);
        end
        img0[256] = 64'hDEAD_BEEF_0123_4567;
        expect_word(0, 'h100, 64'hDEAD_BEEF_0123_4567);
        expect_word(0, 'h300, 64'hDEAD_BEEF_0123_4567);
        sync;
        mem_wr_en = 1'b0;
        drain("cpuwr");
    endtask

    task automatic test_gaps;
        logic [15:0] p [4];
        int          k;
        logic        vpat [7];
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) p[i] = 16'($urandom_range(0, 65535));
        restart(0, "gaps");
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (vpat[i]) begin
                put_parcel(0, p[k], k == 3);
                k++;
            end else begin
                // Invalid cycle carrying junk and a stray last flag.
                ld_parcel = 16'hFFFF;
                ld_last   = 1'b1;
                sync;
                ld_last   = 1'b0;
                n_cmp++;
                if (cpu_rst !== 1'b1) begin
                    n_bad++; $display("FAIL gaps cpu_rst during gap %0d: got 0 expected 1", i);
                end
            end
        end
        expect_word(0, 1, img0[1]);
        drain("gaps");
    endtask

    task automatic test_wrap;
        logic [15:0] p;
        for (int i = 0; i < 12; i++) put_parcel(1, 16'($urandom_range(0, 65535)), 1'b0);
        n_cmp++;
        if (s_ld_ovf !== 1'b0) begin
            n_bad++; $display("FAIL wrap ovf after 3 words: got 1 expected 0");
        end
        for (int i = 0; i < 4; i++) put_parcel(1, 16'($urandom_range(0, 65535)), 1'b0);
        n_cmp++;
        if (s_ld_ovf !== 1'b1) begin
            n_bad++; $display("FAIL wrap ovf after 4 words: got 0 expected 1");
        end
        drain("wrap_a");
        for (int i = 0; i < 4; i++) begin
            p = 16'($urandom_range(0, 65535));
            put_parcel(1, p, i == 3);
        end
        n_cmp++;
        if (s_cpu_rst !== 1'b0) begin
            n_bad++; $display("FAIL wrap cpu_rst after last: got 1 expected 0");
        end
        drain("wrap_b");
        restart(1, "wrap");
        n_cmp++;
        if (s_ld_ovf !== 1'b1) begin
            n_bad++; $display("FAIL wrap ovf after restart: got 0 expected 1");
        end
    endtask

    task automatic test_reset_mid_load;
        restart(0, "midrst");
        for (int i = 0; i < 6; i++) put_parcel(0, 16'($urandom_range(0, 65535)), 1'b0);
        rst = 1'b1;
        sync;
        rst = 1'b0;
        model_reset(0);
        n_cmp++;
        if ({cpu_rst, ld_ready} !== 2'b11) begin
            n_bad++; $display("FAIL midrst {cpu_rst,ready}: got %b expected 11", {cpu_rst, ld_ready});
        end
        expect_word(0, 1, img0[1]);
        drain("midrst");
        // CPU writes must be ignored in LOAD.
        mem_wr_en   = 1'b1;
        mem_addr    = 22'd1;
        mem_wr_data = 64'h0BAD_0BAD_0BAD_0BAD;
        sync;
        mem_wr_en   = 1'b0;
        put_parcel(0, 16'h1357, 1'b0);
        put_parcel(0, 16'h2468, 1'b0);
        // Restart is ignored in LOAD, so the partial word survives it.
        ld_restart = 1'b1;
        sync;
        ld_restart = 1'b0;
        put_parcel(0, 16'hACE0, 1'b0);
        put_parcel(0, 16'hBDF1, 1'b1);
        expect_word(0, 1, img0[1]);
        drain("midrst2");
        n_cmp++;
        if (cpu_rst !== 1'b0) begin
            n_bad++; $display("FAIL midrst2 cpu_rst after last: got 1 expected 0");
        end
        restart(0, "final");
    endtask

    initial begin
        rst = 1'b1;
        mem_addr = '0; mem_wr_data = '0; mem_wr_en = 1'b0;
        ld_valid = 1'b0; ld_parcel = '0; ld_last = 1'b0; ld_restart = 1'b0;
        s_mem_addr = '0; s_mem_wr_data = '0; s_mem_wr_en = 1'b0;
        s_ld_valid = 1'b0; s_ld_parcel = '0; s_ld_last = 1'b0; s_ld_restart = 1'b0;
        test_reset;
        test_image_load;
        test_short_image;
        test_cpu_write;
        test_gaps;
        test_wrap;
        test_reset_mid_load;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
